// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the zero-latency instruction
// memory and loads the IF/ID pipeline register. It honours hazard stalls and
// downstream redirects, and parks in HALT once the program runs out.
//
// Handshake/control contract: there is no valid/ready pair here. On every
// rising edge exactly one action is taken, chosen by priority
// redirect > stall > normal fetch. A redirect always flushes IF/ID to a bubble.
// A stall freezes every register. The fetch state is visible on halted
// (1 = HALT, 0 = RUN).
module if_stage_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] IMEM_LAST_ADDR = 32'd84,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_plus4,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      pc_plus4;
  logic             end_of_program;

  // pc+4 wraps naturally in 32 bits; a zero word or an out-of-range PC ends the program
  always_comb begin
    pc_plus4       = pc_q + 32'd4;
    end_of_program = (pc_q > IMEM_LAST_ADDR) || (imem_instr == 32'h0);
  end

  // Next-state and IF/ID load selection: redirect > stall > fetch/halt
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    cnt_d        = cnt_q;

    if (redirect) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = ST_HALT;
      end else begin
        pc_d    = redirect_target;
        state_d = ST_RUN;
      end
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (end_of_program) begin
            state_d      = ST_HALT;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end else begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_instr;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_HALT: begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
        default: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    imem_addr     = pc_q;
    ifid_pc       = ifid_pc_q;
    ifid_pc_plus4 = ifid_pc4_q;
    ifid_instr    = ifid_instr_q;
    ifid_valid    = ifid_valid_q;
    halted        = (state_q == ST_HALT);
    misalign_err  = misalign_q;
    fetch_count   = cnt_q;
  end

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed bench for if_stage_fetch_unit with a small combinational
// instruction memory model. Program ends at byte address 48.
module tb_if_stage_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:63];
  int          checks;
  int          errors;

  if_stage_fetch_unit #(
    .RESET_PC       (32'h0),
    .IMEM_LAST_ADDR (32'd48),
    .NOP_INSTR      (NOP),
    .CNT_W          (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: words beyond the table read as zero
  always_comb begin
    if (imem_addr[31:8] == 24'h0) imem_instr = mem[imem_addr[7:2]];
    else                          imem_instr = 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    #2;
    checks++; if (imem_addr !== 32'h0)   begin errors++; $display("FAIL rst_addr got %h want %h", imem_addr, 32'h0); end
    checks++; if (ifid_instr !== NOP)    begin errors++; $display("FAIL rst_instr got %h want %h", ifid_instr, NOP); end
    checks++; if ({ifid_valid, halted, misalign_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {ifid_valid, halted, misalign_err}); end
    checks++; if (fetch_count !== 16'd0 || ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_regs cnt %0d pc %h pc4 %h want 0", fetch_count, ifid_pc, ifid_pc_plus4); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ifid_pc !== 32'(i*4)) begin errors++; $display("FAIL fetch_pc%0d got %h want %h", i, ifid_pc, 32'(i*4)); end
      checks++; if (ifid_pc_plus4 !== 32'(i*4+4)) begin errors++; $display("FAIL fetch_pc4_%0d got %h want %h", i, ifid_pc_plus4, 32'(i*4+4)); end
      checks++; if (ifid_instr !== mem[i] || ifid_valid !== 1'b1) begin errors++; $display("FAIL fetch_instr%0d got %h/%b want %h/1", i, ifid_instr, ifid_valid, mem[i]); end
      checks++; if (imem_addr !== 32'(i*4+4)) begin errors++; $display("FAIL fetch_addr%0d got %h want %h", i, imem_addr, 32'(i*4+4)); end
    end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL fetch_cnt got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    stall = 1'b0;
    checks++; if (imem_addr !== 32'd12) begin errors++; $display("FAIL stall_addr got %h want 0c", imem_addr); end
    checks++; if (ifid_pc !== 32'd8 || ifid_instr !== 32'h0000A183 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid got %h/%h/%b want 8/0000a183/1", ifid_pc, ifid_instr, ifid_valid); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", fetch_count); end
    step();
    checks++; if (ifid_pc !== 32'd12 || ifid_instr !== mem[3] || fetch_count !== 16'd4) begin errors++; $display("FAIL stall_resume got %h/%h/%0d want c/%h/4", ifid_pc, ifid_instr, fetch_count, mem[3]); end
  endtask

  task automatic test_redirect();
    step(); // captures pc=16, pc now 20
    checks++; if (imem_addr !== 32'd20) begin errors++; $display("FAIL redir_pre got %h want 14", imem_addr); end
    for (int r = 0; r < 2; r++) begin
      redirect = 1'b1; redirect_target = 32'd24; stall = (r == 1);
      step();
      redirect = 1'b0; stall = 1'b0;
      checks++; if (imem_addr !== 32'd24) begin errors++; $display("FAIL redir%0d_addr got %h want 18", r, imem_addr); end
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin errors++; $display("FAIL redir%0d_bubble got %b/%h want 0/%h", r, ifid_valid, ifid_instr, NOP); end
      checks++; if (ifid_pc !== (r == 0 ? 32'd16 : 32'd24)) begin errors++; $display("FAIL redir%0d_hold got %h", r, ifid_pc); end
      checks++; if (fetch_count !== 16'(5 + r)) begin errors++; $display("FAIL redir%0d_cnt got %0d want %0d", r, fetch_count, 5 + r); end
      step();
      checks++; if (ifid_pc !== 32'd24 || ifid_valid !== 1'b1 || ifid_instr !== mem[6]) begin errors++; $display("FAIL redir%0d_next got %h/%b/%h want 18/1/%h", r, ifid_pc, ifid_valid, ifid_instr, mem[6]); end
    end
    checks++; if (fetch_count !== 16'd7) begin errors++; $display("FAIL redir_cnt got %0d want 7", fetch_count); end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 6; k++) step(); // captures 28..48
    checks++; if (ifid_pc !== 32'd48 || halted !== 1'b0 || imem_addr !== 32'd52) begin errors++; $display("FAIL halt_last got %h/%b/%h want 30/0/34", ifid_pc, halted, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      stall = (k == 2);
      step();
      checks++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 32'd52) begin errors++; $display("FAIL halt%0d got h%b v%b a%h want 1/0/34", k, halted, ifid_valid, imem_addr); end
    end
    stall = 1'b0;
    checks++; if (fetch_count !== 16'd13 || ifid_instr !== NOP) begin errors++; $display("FAIL halt_cnt got %0d/%h want 13/%h", fetch_count, ifid_instr, NOP); end
    redirect = 1'b1; redirect_target = 32'h0;
    step();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL unhalt got %b/%h want 0/0", halted, imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1 || fetch_count !== 16'd14) begin errors++; $display("FAIL restart got %h/%b/%0d want 0/1/14", ifid_pc, ifid_valid, fetch_count); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_target = 32'h0000_0022;
    step();
    redirect = 1'b0;
    checks++; if (misalign_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL mis_flags got %b/%b want 1/1", misalign_err, halted); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || imem_addr !== 32'd4) begin errors++; $display("FAIL mis_bubble got %b/%h/%h want 0/%h/4", ifid_valid, ifid_instr, imem_addr, NOP); end
    step();
    checks++; if (halted !== 1'b1 || imem_addr !== 32'd4 || fetch_count !== 16'd14) begin errors++; $display("FAIL mis_hold got %b/%h/%0d want 1/4/14", halted, imem_addr, fetch_count); end
    redirect = 1'b1; redirect_target = 32'h0;
    step();
    redirect = 1'b0;
    checks++; if (misalign_err !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL mis_sticky got %b/%b want 1/0", misalign_err, halted); end
    step();
    checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1 || fetch_count !== 16'd15) begin errors++; $display("FAIL mis_resume got %h/%b/%0d want 0/1/15", ifid_pc, ifid_valid, fetch_count); end
  endtask

  task automatic test_zero_instr();
    mem[5] = 32'h0;
    redirect = 1'b1; redirect_target = 32'd12;
    step();
    redirect = 1'b0;
    step(); step(); // captures 12 and 16
    checks++; if (ifid_pc !== 32'd16 || fetch_count !== 16'd17) begin errors++; $display("FAIL zero_pre got %h/%0d want 10/17", ifid_pc, fetch_count); end
    step();
    checks++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 32'd20 || fetch_count !== 16'd17) begin errors++; $display("FAIL zero_halt got %b/%b/%h/%0d want 1/0/14/17", halted, ifid_valid, imem_addr, fetch_count); end
    mem[5] = 32'h0000_0293;
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    redirect = 1'b1; redirect_target = 32'h1;
    step();
    redirect = 1'b0;
    checks++; if (halted !== 1'b1 || fetch_count !== 16'd5) begin errors++; $display("FAIL ar_pre got %b/%0d want 1/5", halted, fetch_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 16'd0) begin errors++; $display("FAIL ar_flags got %b/%b/%0d want 0/0/0", halted, misalign_err, fetch_count); end
    checks++; if (imem_addr !== 32'h0 || ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0 || ifid_instr !== NOP || ifid_valid !== 1'b0) begin errors++; $display("FAIL ar_regs got %h/%h/%h/%h/%b", imem_addr, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid); end
    #1 reset = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'h0 || ifid_instr !== mem[0] || ifid_valid !== 1'b1 || fetch_count !== 16'd1) begin errors++; $display("FAIL ar_first got %h/%h/%b/%0d want 0/%h/1/1", ifid_pc, ifid_instr, ifid_valid, fetch_count, mem[0]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
    mem[0] = 32'h00B08133;
    mem[1] = 32'h00A10093;
    mem[2] = 32'h0000A183;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_misalign();
    test_zero_instr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch_unit.md
Name: if_stage_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational, byte-addressed instruction memory.
- Owns the program counter and drives the memory read address. Captures the returned word into the IF/ID pipeline register.
- Applies hazard-unit stalls and branch/jump redirects (flush). Stops fetching cleanly at the end of the populated program.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_LAST_ADDR, 84, highest valid byte address in instruction memory. PC above this halts fetch.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush or halt.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_addr  out  32  read address to instruction memory; equals the PC register (combinational)
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- stall  in  1  hazard-unit load-use stall; hold PC and IF/ID
- redirect  in  1  taken branch/jump resolved downstream; flush and load new PC
- redirect_target  in  32  new PC when redirect=1
- ifid_pc  out  32  PC of instruction in IF/ID
- ifid_pc_plus4  out  32  ifid_pc+4
- ifid_instr  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch state is HALT
- misalign_err  out  1  sticky; a redirect target had bits[1:0]≠0
- fetch_count  out  CNT_W  instructions accepted into IF/ID since reset

Behaviour:
- Reset (async, active-high) sets:
  - pc=RESET_PC, state=RUN
  - ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR, ifid_valid=0
  - halted=0, misalign_err=0, fetch_count=0
- Reset asserted mid-operation discards in-flight state immediately. The first fetch after deassertion is at RESET_PC.
- imem_addr = pc at all times. Memory latency is zero, so the word fetched at pc is captured at the same edge: one cycle from PC to IF/ID.
- State machine has two states, RUN and HALT.
- Per-edge priority is redirect > stall > normal fetch.
- Redirect (any state):
  - If redirect_target[1:0]≠0: set misalign_err=1, state=HALT, pc unchanged.
  - Otherwise: pc=redirect_target, state=RUN.
  - In both cases IF/ID becomes a bubble: ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc/ifid_pc_plus4 hold.
  - fetch_count is unchanged.
  - A redirect asserted together with stall overrides the stall.
- Stall (no redirect): pc, IF/ID, state and fetch_count all hold.
- RUN normal fetch (no stall, no redirect):
  - If pc > IMEM_LAST_ADDR or imem_instr==32'h0: state=HALT, IF/ID becomes a bubble, pc holds.
  - Otherwise: ifid_pc=pc, ifid_pc_plus4=pc+4, ifid_instr=imem_instr, ifid_valid=1, pc=pc+4, fetch_count+1.
- HALT (no redirect): pc holds. Every unstalled edge loads a bubble into IF/ID. Only a valid redirect returns to RUN.
- halted = (state==HALT), registered.
- Arithmetic rules:
  - pc+4 wraps modulo 2^32.
  - fetch_count saturates at all-ones and does not wrap.
- misalign_err is cleared only by reset.

Test Plan:
- Reset then release, memory loaded with 0x00B08133 @0, 0x00A10093 @4, 0x0000A183 @8, no stall -> after edges 1, 2, 3: ifid_pc=0, 4, 8; ifid_instr matches; ifid_valid=1; imem_addr=4, 8, 12; fetch_count=3.
- stall=1 for 1 cycle while pc=12 -> imem_addr stays 12; IF/ID still holds pc=8/0x0000A183; fetch_count unchanged; next edge captures pc=12.
- redirect=1, target=24 while pc=20 -> next edge: imem_addr=24, ifid_valid=0, ifid_instr=0x00000013; following edge: ifid_pc=24, valid=1. Repeat with stall=1 on the same cycle -> redirect wins, identical result.
- IMEM_LAST_ADDR=48, straight-line run -> after capturing pc=48: halted=1, pc holds at 52, ifid_valid=0 every later cycle, fetch_count=13. Then redirect to 0 -> halted=0 and fetch restarts at 0.
- redirect target=0x0000_0022 -> misalign_err=1, halted=1, IF/ID bubble. misalign_err stays 1 after a later valid redirect to 0; fetch resumes.
- Assert reset asynchronously mid-cycle while halted with fetch_count=5 -> outputs return to reset values immediately without waiting for a clk edge.
